// File: rtl/q_sys_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// q_sys_pll_lock_supervisor
//
// Purpose
//   Sequences the reset input of a PLL and watches its locked output. The
//   block runs on the free-running PLL reference clock, so it keeps working
//   while the PLL itself is unlocked. It pulses the PLL reset, waits for the
//   PLL to lock, and checks that the lock is stable for a qualification window.
//   Only then does it release the system reset for the PLL clock domain.
//   If the lock does not arrive in time it retries a bounded number of times
//   and then reports a permanent failure. If the lock is lost while running,
//   it starts the whole sequence again.
//
// Parameters
//   PLL_RST_CYCLES      cycles pll_rst is held high per attempt (>=1)
//   LOCK_STABLE_CYCLES  consecutive synchronized-locked cycles before release (>=1)
//   LOCK_TIMEOUT_CYCLES max cycles spent waiting for lock before a retry (>=2)
//   MAX_RETRIES         retries after the first attempt before failing (0..15)
//   SYNC_STAGES         flops in the pll_locked synchronizer (>=2)
//
// Ports
//   refclk        in   reference clock, the only clock of this block
//   rst           in   asynchronous active-high reset
//   pll_locked    in   PLL locked indication, asynchronous to refclk
//   force_relock  in   one-cycle request to restart the sequence; clears retries
//   pll_rst       out  reset to the PLL
//   sys_rst       out  active-high system reset request, low only while running
//   ready         out  high only while running
//   lock_lost     out  one-cycle pulse when the lock drops while running
//   lock_fail     out  high while in the permanent-failure state
//   retry_count   out  retries used so far in the current sequence
// -----------------------------------------------------------------------------
module q_sys_pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES         = 7,
  parameter int SYNC_STAGES         = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic       lock_fail,
  output logic [3:0] retry_count
);

  // ---------------------------------------------------------------------------
  // Parameter sanity
  // ---------------------------------------------------------------------------
  if (PLL_RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("PLL_RST_CYCLES must be at least 1");
  end
  if (LOCK_STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("LOCK_STABLE_CYCLES must be at least 1");
  end
  if (LOCK_TIMEOUT_CYCLES < 2) begin : g_bad_timeout_cycles
    $error("LOCK_TIMEOUT_CYCLES must be at least 2");
  end
  if (MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_max_retries
    $error("MAX_RETRIES must be in 0..15");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // Counter sizing: a single counter is shared by every timed state, so it is
  // sized for the longest interval any state has to measure.
  // ---------------------------------------------------------------------------
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                           PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        retry_d;
  logic              lock_lost_d;
  logic              pll_rst_d, sys_rst_d, ready_d, lock_fail_d;

  // ---------------------------------------------------------------------------
  // pll_locked synchronizer. locked_s is pll_locked delayed by SYNC_STAGES
  // refclk edges.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_count;
    lock_lost_d = 1'b0;

    if (force_relock && state_q != RESET_PLL) begin
      // Operator restart beats every other condition and gives the new
      // sequence its full retry budget. It is not a lock loss, so lock_lost
      // is not pulsed.
      state_d = RESET_PLL;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end

        WAIT_LOCK: begin
          // If lock arrives on the timeout cycle, the lock is taken.
          if (locked_s) begin
            state_d = STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_count == RETRY_LIMIT) begin
              state_d = FAIL;
            end else begin
              state_d = RESET_PLL;
              retry_d = retry_count + 4'd1;
            end
          end
        end

        STABLE: begin
          // A dropout during qualification is treated as a glitch. The PLL is
          // not reset and no retry is consumed; qualification starts again
          // once lock returns.
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
          end
        end

        RUN: begin
          if (!locked_s) begin
            state_d     = RESET_PLL;
            retry_d     = 4'd0;
            lock_lost_d = 1'b1;
          end
        end

        FAIL: begin
          state_d = FAIL;
        end

        default: begin
          state_d = RESET_PLL;
          retry_d = 4'd0;
        end
      endcase
    end

    // The counter clears on every state change. Otherwise it counts up and
    // holds at all-ones instead of wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // The outputs are decoded from the next state and registered, so they
    // change on the same edge as the state.
    pll_rst_d   = (state_d == RESET_PLL);
    sys_rst_d   = (state_d != RUN);
    ready_d     = (state_d == RUN);
    lock_fail_d = (state_d == FAIL);
  end

  // ---------------------------------------------------------------------------
  // State, counter and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: only control flops exist here. There is no memory array, so every
  // register takes the asynchronous reset.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_count <= 4'd0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      lock_fail   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_count <= retry_d;
      pll_rst     <= pll_rst_d;
      sys_rst     <= sys_rst_d;
      ready       <= ready_d;
      lock_lost   <= lock_lost_d;
      lock_fail   <= lock_fail_d;
    end
  end

endmodule

// File: tb/tb_q_sys_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_q_sys_pll_lock_supervisor
//
// This bench checks q_sys_pll_lock_supervisor with small parameters
// (PLL_RST=4, STABLE=8, TIMEOUT=20, RETRIES=2, SYNC=2). Each stimulus segment
// holds the inputs for N cycles and states the outputs expected after each of
// those edges. As each cycle is driven, its expected outputs go into a
// scoreboard queue. A negedge monitor pops each entry and compares it once
// its edge has occurred. Reset behaviour is checked by hand-written sequences.
// Edge k is the k-th refclk rising edge after rst is released.
// -----------------------------------------------------------------------------
module tb_q_sys_pll_lock_supervisor;

  localparam int P_RST     = 4;
  localparam int P_STABLE  = 8;
  localparam int P_TIMEOUT = 20;
  localparam int P_RETRIES = 2;
  localparam int P_SYNC    = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst, sys_rst, ready, lock_lost, lock_fail;
  logic [3:0] retry_count;

  q_sys_pll_lock_supervisor #(
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_STABLE_CYCLES  (P_STABLE),
    .LOCK_TIMEOUT_CYCLES (P_TIMEOUT),
    .MAX_RETRIES         (P_RETRIES),
    .SYNC_STAGES         (P_SYNC)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .lock_fail    (lock_fail),
    .retry_count  (retry_count)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic       lock_fail;
    logic [3:0] retry_count;
  } outs_t;

  typedef struct {
    string name;
    int    n;
    bit    locked;
    bit    force_r;
    outs_t exp;
  } seg_t;

  typedef struct {
    string name;
    int    due;
    outs_t exp;
  } sb_item_t;

  seg_t     segs[$];
  sb_item_t sb[$];
  sb_item_t mon_item;
  int       n_checks = 0;
  int       n_fail   = 0;
  int       edge_cnt;
  outs_t    act;

  assign act = {pll_rst, sys_rst, ready, lock_lost, lock_fail, retry_count};

  always @(posedge refclk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  function automatic outs_t mk(input logic p, input logic s, input logic r,
                               input logic ll, input logic lf, input logic [3:0] rc);
    mk = {p, s, r, ll, lf, rc};
  endfunction

  function automatic string fmt(input outs_t o);
    fmt = $sformatf("pll_rst=%b sys_rst=%b ready=%b lock_lost=%b lock_fail=%b retry_count=%0d",
                    o.pll_rst, o.sys_rst, o.ready, o.lock_lost, o.lock_fail, o.retry_count);
  endfunction

  task automatic check(input string name, input outs_t got, input outs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
    end
  endtask

  // Scoreboard monitor: it compares every entry whose edge has already occurred.
  always @(negedge refclk) begin
    while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      mon_item = sb.pop_front();
      check($sformatf("%s@edge%0d", mon_item.name, mon_item.due), act, mon_item.exp);
    end
  end

  task automatic add_seg(input string name, input int n, input bit l, input bit f,
                         input outs_t e);
    seg_t s;
    s.name    = name;
    s.n       = n;
    s.locked  = l;
    s.force_r = f;
    s.exp     = e;
    segs.push_back(s);
  endtask

  // Each call is entered about 1 ns after a rising edge, and it leaves at the same point.
  task automatic run_segs();
    sb_item_t it;
    foreach (segs[k]) begin
      for (int i = 0; i < segs[k].n; i++) begin
        pll_locked   = segs[k].locked;
        force_relock = segs[k].force_r;
        it.name = $sformatf("%s[%0d]", segs[k].name, i);
        it.due  = edge_cnt + 1;
        it.exp  = segs[k].exp;
        sb.push_back(it);
        @(posedge refclk);
        #1;
      end
    end
    force_relock = 1'b0;
    segs.delete();
  endtask

  // rst is asserted mid-cycle and checked before any edge, then held across
  // two edges and released 1 ns after a rising edge.
  task automatic do_reset(input string name);
    outs_t rst_o;
    rst_o = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge refclk);
    #1;
    rst = 1'b1;
    #1;
    check({name, "_async"}, act, rst_o);
    @(posedge refclk);
    @(posedge refclk);
    #1;
    check({name, "_held"}, act, rst_o);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    outs_t r0, r1, r2, w0, w1, w2, run_o;
    r0    = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    r1    = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    r2    = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    w0    = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    w1    = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    w2    = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    run_o = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    // ---- Main scenario: tests 1, 4, 3, 2, 5 run back to back ----
    do_reset("reset0");
    // 1: clean lock. PLL reset after edges 1-3, low from edge 4, STABLE at edge 5, RUN at edge 13.
    add_seg("t1_pll_rst",     3, 1, 0, r0);
    add_seg("t1_wait_stable", 9, 1, 0, w0);     // edges 4-12
    add_seg("t1_run",         4, 1, 0, run_o);  // edges 13-16
    // 4: the lock drops in RUN. The FSM sees it two edges after it is sampled.
    add_seg("t4_drop",        2, 0, 0, run_o);  // edges 17-18
    add_seg("t4_lost",        1, 1, 0, mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0)); // edge 19
    add_seg("t4_pll_rst",     3, 1, 0, r0);     // edges 20-22
    add_seg("t4_requal",      9, 1, 0, w0);     // edges 23-31
    add_seg("t4_run",         2, 1, 0, run_o);  // edges 32-33
    // force_relock in RUN restarts the sequence without a lock_lost pulse.
    add_seg("t5_force_run",   1, 1, 1, r0);     // edge 34
    add_seg("t3_pll_rst",     1, 1, 0, r0);     // edge 35
    add_seg("t3_force_ign",   1, 1, 1, r0);     // edge 36: ignored in RESET_PLL
    add_seg("t3_pll_rst_end", 1, 1, 0, r0);     // edge 37
    // 3: a one-cycle glitch while STABLE is at count 5 forces a full requalification.
    add_seg("t3_stable",      5, 1, 0, w0);     // edges 38-42
    add_seg("t3_glitch",      1, 0, 0, w0);     // edge 43
    add_seg("t3_requal",     10, 1, 0, w0);     // edges 44-53
    add_seg("t3_run",         2, 1, 0, run_o);  // edges 54-55
    // 2: the PLL never locks. Three attempts, then FAIL.
    add_seg("t2_force",       1, 0, 1, r0);     // edge 56
    add_seg("t2_rst0",        3, 0, 0, r0);     // edges 57-59
    add_seg("t2_wait0",      20, 0, 0, w0);     // edges 60-79
    add_seg("t2_rst1",        4, 0, 0, r1);     // edges 80-83
    add_seg("t2_wait1",      20, 0, 0, w1);
    add_seg("t2_rst2",        4, 0, 0, r2);
    add_seg("t2_wait2",      20, 0, 0, w2);
    add_seg("t2_fail",        5, 0, 0, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2)); // edges 128-132
    // 5: force_relock out of FAIL, and this time the PLL locks.
    add_seg("t5_force_fail",  1, 1, 1, r0);     // edge 133
    add_seg("t5_pll_rst",     3, 1, 0, r0);     // edges 134-136
    add_seg("t5_requal",      9, 1, 0, w0);     // edges 137-145
    add_seg("t5_run",         3, 1, 0, run_o);  // edges 146-148
    run_segs();

    // ---- Lock arrives on the timeout cycle: the lock must win ----
    do_reset("reset1");
    add_seg("tw_pll_rst",     3, 0, 0, r0);     // edges 1-3
    add_seg("tw_wait",       18, 0, 0, w0);     // edges 4-21
    add_seg("tw_lock",       10, 1, 0, w0);     // edges 22-31; the timeout edge is 24
    add_seg("tw_run",         2, 1, 0, run_o);  // edges 32-33
    run_segs();

    // ---- 6: asynchronous rst mid-STABLE ----
    do_reset("reset2");
    add_seg("t6_pll_rst",     3, 1, 0, r0);
    add_seg("t6_stable",      5, 1, 0, w0);     // STABLE since edge 5
    run_segs();
    do_reset("t6_mid_stable");

    // Drain the scoreboard and confirm that every entry has been compared.
    @(negedge refclk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
